// File: rtl/apb_svt_decoder_bridge.sv
// APB one-master to N-slave decoding bridge with fully registered outputs,
// per-slave address windows, an ACCESS-wait timeout and a saturating error counter.
module apb_svt_decoder_bridge #(
   parameter int NUM_SLAVES     = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int REGION_BITS    = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             pclk,
   input  logic                             presetn,
   input  logic                             psel_m,
   input  logic                             penable_m,
   input  logic                             pwrite_m,
   input  logic [ADDR_WIDTH-1:0]            paddr_m,
   input  logic [DATA_WIDTH-1:0]            pwdata_m,
   input  logic [DATA_WIDTH/8-1:0]          pstrb_m,
   input  logic [2:0]                       pprot_m,
   output logic [DATA_WIDTH-1:0]            prdata_m,
   output logic                             pready_m,
   output logic                             pslverr_m,
   output logic [NUM_SLAVES-1:0]            psel_s,
   output logic                             penable_s,
   output logic                             pwrite_s,
   output logic [ADDR_WIDTH-1:0]            paddr_s,
   output logic [DATA_WIDTH-1:0]            pwdata_s,
   output logic [DATA_WIDTH/8-1:0]          pstrb_s,
   output logic [2:0]                       pprot_s,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_s,
   input  logic [NUM_SLAVES-1:0]            pready_s,
   input  logic [NUM_SLAVES-1:0]            pslverr_s,
   output logic [7:0]                       err_count
);

   // Handshake: a request is accepted only in IDLE on psel_m & !penable_m;
   // pready_m is a single-cycle completion pulse carrying prdata_m/pslverr_m.
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam int          IW       = ADDR_WIDTH - REGION_BITS;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]            state;
   logic [15:0]           wait_cnt;
   logic [IW-1:0]         dec_idx;
   logic [NUM_SLAVES-1:0] dec_onehot;
   logic                  dec_hit;
   logic                  slave_ready;
   logic                  slave_err;
   logic [DATA_WIDTH-1:0] slave_rdata;
   logic                  tmo_hit;
   logic [7:0]            err_inc;

   assign dec_idx = paddr_m[ADDR_WIDTH-1:REGION_BITS];

   // psel_s is one-hot in SETUP/ACCESS, so it doubles as the slave mux select.
   always_comb begin
      dec_onehot  = '0;
      slave_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         dec_onehot[i] = (dec_idx == IW'(i));
         if (psel_s[i])
            slave_rdata = slave_rdata | prdata_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign dec_hit     = |dec_onehot;
   assign slave_ready = |(pready_s & psel_s);
   assign slave_err   = |(pslverr_s & psel_s);
   assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (wait_cnt == TMO_LAST);
   assign err_inc     = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         prdata_m  <= '0;
         pready_m  <= 1'b0;
         pslverr_m <= 1'b0;
         psel_s    <= '0;
         penable_s <= 1'b0;
         pwrite_s  <= 1'b0;
         paddr_s   <= '0;
         pwdata_s  <= '0;
         pstrb_s   <= '0;
         pprot_s   <= '0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (psel_m && !penable_m) begin
                  paddr_s  <= paddr_m;
                  pwrite_s <= pwrite_m;
                  pwdata_s <= pwdata_m;
                  pstrb_s  <= pstrb_m;
                  pprot_s  <= pprot_m;
                  if (dec_hit) begin
                     psel_s <= dec_onehot;
                     state  <= SETUP;
                  end else begin
                     prdata_m  <= '0;
                     pslverr_m <= 1'b1;
                     pready_m  <= 1'b1;
                     err_count <= err_inc;
                     state     <= RESP;
                  end
               end
            end
            SETUP: begin
               penable_s <= 1'b1;
               wait_cnt  <= '0;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (slave_ready) begin
                  psel_s    <= '0;
                  penable_s <= 1'b0;
                  prdata_m  <= pwrite_s ? '0 : slave_rdata;
                  pslverr_m <= slave_err;
                  pready_m  <= 1'b1;
                  if (slave_err)
                     err_count <= err_inc;
                  state <= RESP;
               end else if (tmo_hit) begin
                  psel_s    <= '0;
                  penable_s <= 1'b0;
                  prdata_m  <= '0;
                  pslverr_m <= 1'b1;
                  pready_m  <= 1'b1;
                  err_count <= err_inc;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            RESP: begin
               pready_m  <= 1'b0;
               pslverr_m <= 1'b0;
               prdata_m  <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_svt_decoder_bridge.sv
// Directed bench for apb_svt_decoder_bridge: a driver issues master transfers and
// queues expected responses, a negedge monitor checks each pready_m pulse.
module tb_apb_svt_decoder_bridge;

   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic           pclk;
   logic           presetn;
   logic           psel_m, penable_m, pwrite_m;
   logic [AW-1:0]  paddr_m;
   logic [DW-1:0]  pwdata_m;
   logic [DW/8-1:0] pstrb_m;
   logic [2:0]     pprot_m;
   logic [DW-1:0]  prdata_m;
   logic           pready_m, pslverr_m;
   logic [NS-1:0]  psel_s;
   logic           penable_s, pwrite_s;
   logic [AW-1:0]  paddr_s;
   logic [DW-1:0]  pwdata_s;
   logic [DW/8-1:0] pstrb_s;
   logic [2:0]     pprot_s;
   logic [NS*DW-1:0] prdata_s;
   logic [NS-1:0]  pready_s, pslverr_s;
   logic [7:0]     err_count;

   apb_svt_decoder_bridge #(
      .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .REGION_BITS(12), .TIMEOUT_CYCLES(16)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .psel_m(psel_m), .penable_m(penable_m), .pwrite_m(pwrite_m),
      .paddr_m(paddr_m), .pwdata_m(pwdata_m), .pstrb_m(pstrb_m), .pprot_m(pprot_m),
      .prdata_m(prdata_m), .pready_m(pready_m), .pslverr_m(pslverr_m),
      .psel_s(psel_s), .penable_s(penable_s), .pwrite_s(pwrite_s),
      .paddr_s(paddr_s), .pwdata_s(pwdata_s), .pstrb_s(pstrb_s), .pprot_s(pprot_s),
      .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s),
      .err_count(err_count)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  exp_ec = 8'd0;
   logic [31:0] slv_data[NS];
   int          slv_wait[NS];
   logic [NS-1:0] slv_err;
   int          acc_cnt = 0;

   // clock / reset
   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // slave model: selected slave answers after slv_wait ACCESS cycles
   initial begin
      pready_s = '0;
      forever begin
         @(negedge pclk);
         for (int i = 0; i < NS; i++) prdata_s[i*DW +: DW] = slv_data[i];
         pslverr_s = slv_err;
         pready_s  = '0;
         if (penable_s) begin
            for (int i = 0; i < NS; i++)
               if (psel_s[i] && acc_cnt >= slv_wait[i]) pready_s[i] = 1'b1;
            acc_cnt++;
         end else begin
            acc_cnt = 0;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (presetn && psel_s != '0)
            chk("psel_onehot", 32'($countones(psel_s)), 32'd1);
         if (presetn && pready_m) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pready", 32'(pready_m), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_prdata", prdata_m, e.rdata);
               chk("resp_pslverr", 32'(pslverr_m), 32'(e.err));
               chk("resp_cycle", 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   // driver: starts in an IDLE cycle (#1 after posedge), returns in the next IDLE cycle
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [NS-1:0] exp_sel, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat);
      exp_t e;
      bit   done;
      psel_m = 1'b1; penable_m = 1'b0; paddr_m = addr; pwrite_m = wr;
      pwdata_m = wdata; pstrb_m = 4'hF; pprot_m = 3'b010;
      e.rdata = exp_rdata; e.err = exp_err; e.due = cyc + exp_lat;
      exp_q.push_back(e);
      if (exp_err) exp_ec = (exp_ec == 8'hFF) ? 8'hFF : exp_ec + 8'd1;
      done = 1'b0;
      for (int k = 1; k <= 64 && !done; k++) begin
         @(posedge pclk); #1;
         penable_m = 1'b1;
         if (k == 1) begin
            chk("psel_t1", 32'(psel_s), 32'(exp_sel));
            chk("penable_t1", 32'(penable_s), 32'd0);
            if (exp_sel != '0) begin
               chk("paddr_s", paddr_s, addr);
               chk("pwrite_s", 32'(pwrite_s), 32'(wr));
               chk("pwdata_s", pwdata_s, wdata);
            end
         end
         if (k == 2 && exp_sel != '0) begin
            chk("psel_t2", 32'(psel_s), 32'(exp_sel));
            chk("penable_t2", 32'(penable_s), 32'd1);
         end
         if (pready_m) begin
            done = 1'b1;
            chk("psel_resp", 32'(psel_s), 32'd0);
            chk("penable_resp", 32'(penable_s), 32'd0);
         end
      end
      if (!done) chk("pready_timeout", 32'(pready_m), 32'd1);
      psel_m = 1'b0; penable_m = 1'b0;
      @(posedge pclk); #1;
      chk("pready_low_after", 32'(pready_m), 32'd0);
      chk("err_count", 32'(err_count), 32'(exp_ec));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_psel_s"}, 32'(psel_s), 32'd0);
      chk({tag, "_penable_s"}, 32'(penable_s), 32'd0);
      chk({tag, "_pready_m"}, 32'(pready_m), 32'd0);
      chk({tag, "_pslverr_m"}, 32'(pslverr_m), 32'd0);
      chk({tag, "_prdata_m"}, prdata_m, 32'd0);
      chk({tag, "_paddr_s"}, paddr_s, 32'd0);
      chk({tag, "_pwdata_s"}, pwdata_s, 32'd0);
      chk({tag, "_pstrb_s"}, 32'(pstrb_s), 32'd0);
      chk({tag, "_pprot_s"}, 32'(pprot_s), 32'd0);
      chk({tag, "_pwrite_s"}, 32'(pwrite_s), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
      chk({tag, "_state"}, 32'(dut.state), 32'd0);
   endtask

   // main stimulus
   initial begin
      presetn = 1'b0; psel_m = 1'b0; penable_m = 1'b0; pwrite_m = 1'b0;
      paddr_m = '0; pwdata_m = '0; pstrb_m = '0; pprot_m = '0;
      slv_err = '0;
      for (int i = 0; i < NS; i++) begin
         slv_data[i] = 32'h0;
         slv_wait[i] = 0;
      end
      repeat (3) @(posedge pclk);
      #1;
      chk_zero("reset");
      presetn = 1'b1;

      // write 0x1004 to slave 1, ready at once; write returns zero data
      slv_data[1] = 32'h1111_1111;
      xfer(32'h0000_1004, 1'b1, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0, 3);
      // read 0x3010 from slave 3 with 2 wait states
      slv_data[3] = 32'hDEAD_BEEF; slv_wait[3] = 2;
      xfer(32'h0000_3010, 1'b0, 32'h0, 4'b1000, 32'hDEAD_BEEF, 1'b0, 5);
      // last word of region 0
      slv_data[0] = 32'h0BAD_F00D;
      xfer(32'h0000_0FFC, 1'b0, 32'h0, 4'b0001, 32'h0BAD_F00D, 1'b0, 3);
      // unmapped: idx 5 and first unmapped idx 4
      xfer(32'h0000_5000, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
      xfer(32'h0000_4000, 1'b1, 32'h1234_5678, 4'b0000, 32'h0, 1'b1, 1);
      // slave error with one wait state: read data still returned
      slv_data[0] = 32'h1234_5678; slv_wait[0] = 1; slv_err = 4'b0001;
      xfer(32'h0000_0008, 1'b0, 32'h0, 4'b0001, 32'h1234_5678, 1'b1, 4);
      slv_err = '0; slv_wait[0] = 0;
      // timeout: slave 2 never ready, 16 ACCESS cycles then RESP
      slv_data[2] = 32'hCAFE_CAFE; slv_wait[2] = 1000;
      xfer(32'h0000_2000, 1'b0, 32'h0, 4'b0100, 32'h0, 1'b1, 18);

      // penable_m=1 in IDLE must not start a transfer
      psel_m = 1'b1; penable_m = 1'b1; paddr_m = 32'h0000_1000; pwrite_m = 1'b0;
      repeat (2) begin
         @(posedge pclk); #1;
         chk("ignored_psel_s", 32'(psel_s), 32'd0);
         chk("ignored_pready_m", 32'(pready_m), 32'd0);
      end
      psel_m = 1'b0; penable_m = 1'b0;

      // saturating error counter
      for (int n = 0; n < 300; n++)
         xfer(32'h0000_7000 + 32'(n), 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
      chk("err_count_sat", 32'(err_count), 32'd255);

      // reset in the middle of ACCESS to slave 2
      psel_m = 1'b1; penable_m = 1'b0; paddr_m = 32'h0000_2000; pwrite_m = 1'b0;
      @(posedge pclk); #1;
      penable_m = 1'b1;
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      chk("pre_reset_penable_s", 32'(penable_s), 32'd1);
      presetn = 1'b0;
      @(posedge pclk); #1;
      chk_zero("midreset");
      presetn = 1'b1; psel_m = 1'b0; penable_m = 1'b0;
      exp_ec = 8'd0;
      repeat (3) @(posedge pclk);
      #1;
      chk("post_reset_pready_m", 32'(pready_m), 32'd0);

      // recovery transfer
      slv_data[0] = 32'h5555_AAAA; slv_wait[0] = 0;
      xfer(32'h0000_0004, 1'b0, 32'h0, 4'b0001, 32'h5555_AAAA, 1'b0, 3);

      repeat (2) @(posedge pclk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
